// File: rtl/tank_pkg.sv
// Shared tank-war definitions: directions, cell categories, playfield
// defaults and a direction legality helper.
package tank_pkg;

  localparam int DIR_W = 3;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    WALL   = 2'd1,
    TANK   = 2'd2,
    BULLET = 2'd3
  } cat_e;

  localparam int DEF_GRID_W         = 60;
  localparam int DEF_GRID_H         = 45;
  localparam int DEF_BLOCK_SIZE     = 10;
  localparam int DEF_BOUNDARY_WIDTH = 20;

  // Only the four cardinal codes name a real heading.
  function automatic logic dir_legal(input logic [DIR_W-1:0] d);
    return d <= DIR_W'(3);
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Spawn handshake and renderer query bundle for bullet_pool.
interface bullet_pool_if
  import tank_pkg::*;
#(
  parameter int COORD_W = 10
);
  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic [DIR_W-1:0]   spawn_dir;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               query_hit;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_dir, query_x, query_y,
    input  spawn_ready, query_hit
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_dir, query_x, query_y,
    output spawn_ready, query_hit
  );
endinterface

// File: rtl/bullet_step.sv
// Next grid position of one bullet and whether it leaves the playfield.
// With BULLET_WRAP_EN defined, bullets wrap to the opposite edge instead
// of retiring.
module bullet_step
  import tank_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  dir_e               dir,
  output logic [COORD_W-1:0] x_nxt,
  output logic [COORD_W-1:0] y_nxt,
  output logic               retire
);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  // Edge test happens before the +/-1 so x/y never underflow.
  always_comb begin
    x_nxt  = x;
    y_nxt  = y;
    retire = 1'b0;
    case (dir)
      LEFT: begin
        if (x == '0) begin
`ifdef BULLET_WRAP_EN
          x_nxt = X_MAX;
`else
          retire = 1'b1;
`endif
        end else begin
          x_nxt = x - ONE;
        end
      end
      RIGHT: begin
        if (x == X_MAX) begin
`ifdef BULLET_WRAP_EN
          x_nxt = '0;
`else
          retire = 1'b1;
`endif
        end else begin
          x_nxt = x + ONE;
        end
      end
      UP: begin
        if (y == '0) begin
`ifdef BULLET_WRAP_EN
          y_nxt = Y_MAX;
`else
          retire = 1'b1;
`endif
        end else begin
          y_nxt = y - ONE;
        end
      end
      default: begin
        if (y == Y_MAX) begin
`ifdef BULLET_WRAP_EN
          y_nxt = '0;
`else
          retire = 1'b1;
`endif
        end else begin
          y_nxt = y + ONE;
        end
      end
    endcase
  end
endmodule

// File: rtl/bullet_pool.sv
// Fixed-slot bullet pool: spawns into the lowest free slot, sweeps one slot
// per cycle on each step tick, answers a registered occupancy query.
// Edge behaviour selected by BULLET_WRAP_EN (see bullet_step).
//
// state   | meaning
// S_IDLE  | accepting spawns, waiting for a step tick (or pending tick)
// S_SWEEP | moving/retiring slot ptr, one slot per cycle
module bullet_pool
  import tank_pkg::*;
#(
  parameter int MAX_BULLETS = 16,
  parameter int COORD_W     = 10,
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H
) (
  input  logic                               clk_100mhz,
  input  logic                               rst_n,
  bullet_pool_if.slave                       bus,
  input  logic                               step_tick,
  output logic                               busy,
  output logic [$clog2(MAX_BULLETS+1)-1:0]   n_active,
  output logic                               tick_overrun
);
  localparam int PW = $clog2(MAX_BULLETS);
  localparam int NW = $clog2(MAX_BULLETS + 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NW-1:0]      n_q, n_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               ready_q, ready_d;
  logic               hit_q, hit_d;

  logic               valid_q [MAX_BULLETS];
  logic [COORD_W-1:0] x_q     [MAX_BULLETS];
  logic [COORD_W-1:0] y_q     [MAX_BULLETS];
  dir_e               dir_q   [MAX_BULLETS];

  logic               spawn_legal, wr_en, mv_en, rt_en;
  logic [PW-1:0]      free_idx;
  logic [COORD_W-1:0] step_x, step_y;
  logic               step_retire;

  bullet_step #(
    .COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) u_step (
    .x      (x_q[ptr_q]),
    .y      (y_q[ptr_q]),
    .dir    (dir_q[ptr_q]),
    .x_nxt  (step_x),
    .y_nxt  (step_y),
    .retire (step_retire)
  );

  assign spawn_legal = (bus.spawn_x < COORD_W'(GRID_W)) &&
                       (bus.spawn_y < COORD_W'(GRID_H)) &&
                       dir_legal(bus.spawn_dir);

  // Lowest-index free slot; only used when ready guarantees one exists.
  always_comb begin
    free_idx = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = PW'(i);
    end
  end

  // Occupancy match against the slot state presented this cycle.
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (valid_q[i] && x_q[i] == bus.query_x && y_q[i] == bus.query_y) hit_d = 1'b1;
    end
  end

  // Next-state, tick bookkeeping and slot write enables.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    n_d       = n_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    mv_en     = 1'b0;
    rt_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_en = bus.spawn_valid && ready_q && spawn_legal;
        if (wr_en) n_d = n_q + NW'(1);
        if (step_tick || pending_q) begin
          state_d   = S_SWEEP;
          ptr_d     = '0;
          pending_d = 1'b0;
          // A pending tick is consumed here, so a fresh one is lost.
          if (step_tick && pending_q) overrun_d = 1'b1;
        end
      end
      default: begin
        if (valid_q[ptr_q]) begin
          if (step_retire) begin
            rt_en = 1'b1;
            n_d   = n_q - NW'(1);
          end else begin
            mv_en = 1'b1;
          end
        end
        if (step_tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (ptr_q == PW'(MAX_BULLETS - 1)) state_d = S_IDLE;
        else                               ptr_d   = ptr_q + PW'(1);
      end
    endcase
    // Registered so spawn_ready stays low through reset.
    ready_d = (state_d == S_IDLE) && (n_d < NW'(MAX_BULLETS));
  end

  // Control registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      n_q       <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      ready_q   <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      n_q       <= n_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ready_q   <= ready_d;
      hit_q     <= hit_d;
    end
  end

  // Slot storage: spawn writes the free slot, sweep updates slot ptr.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        valid_q[i] <= 1'b0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dir_q[i]   <= LEFT;
      end
    end else begin
      if (wr_en) begin
        valid_q[free_idx] <= 1'b1;
        x_q[free_idx]     <= bus.spawn_x;
        y_q[free_idx]     <= bus.spawn_y;
        dir_q[free_idx]   <= dir_e'(bus.spawn_dir[1:0]);
      end
      if (mv_en) begin
        x_q[ptr_q] <= step_x;
        y_q[ptr_q] <= step_y;
      end
      if (rt_en) valid_q[ptr_q] <= 1'b0;
    end
  end

  assign bus.spawn_ready = ready_q;
  assign bus.query_hit   = hit_q;
  assign busy            = (state_q == S_SWEEP);
  assign n_active        = n_q;
  assign tick_overrun    = overrun_q;

endmodule
